// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: FSM encoding and pointer sizing.
// Pointer width carries one extra wrap bit above the entry index.
package branch_resolve_queue_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brq_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_bp_ptr_fifo.sv
// 1-bit circular prediction buffer with wrap-bit pointers; head is read combinationally.
// Flush discards everything younger than the (post-pop) head and ignores a same-cycle push.
module bp_ptr_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW-1:0] o_occupancy
);

  localparam int IW = PW - 1;

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_nxt;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) &&
                       (r_wr_ptr[IW] != r_rd_ptr[IW]);
  assign o_occupancy = r_wr_ptr - r_rd_ptr;
  assign o_head      = r_mem[r_rd_ptr[IW-1:0]];

  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_rd_nxt  = w_pop_ok ? r_rd_ptr + PW'(1) : r_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      // A flush collapses the queue onto the entry after the one just popped.
      if (i_flush)        r_wr_ptr <= w_rd_nxt;
      else if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[IW-1:0]] <= i_din;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds per-branch predictions until resolve, compares with outcome, drives predictor
// training, mispredict flush pulse and a saturating mispredict counter; 1-cycle resolve latency.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter int  CNT_W     = 8,
  parameter int  FLUSH_CYC = 2,
  localparam int PW        = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_pred,
  output logic             issue_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             update_valid,
  output logic             update_taken,
  output logic             mispredict,
  output logic             underflow,
  output logic [PW-1:0]    occupancy,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  brq_state_e    r_state;
  brq_state_e    w_state_nxt;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nxt;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_issue_acc;
  logic w_res_acc;
  logic w_mis;

  assign w_issue_acc = issue_valid && issue_ready;
  assign w_res_acc   = resolve_valid && !w_empty && (r_state == ST_RUN);
  assign w_mis       = w_res_acc && (w_head != resolve_taken);

  bp_ptr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_issue_acc),
    .i_din       (issue_pred),
    .i_pop       (w_res_acc),
    .i_flush     (w_mis),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    issue_ready = 1'b0;
    case (r_state)
      ST_RUN: begin
        issue_ready = !w_full;
        if (w_mis) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (r_fcnt == '0) w_state_nxt = ST_RUN;
        else              w_fcnt_nxt  = r_fcnt - FW'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_valid     <= 1'b0;
      update_taken     <= 1'b0;
      mispredict       <= 1'b0;
      underflow        <= 1'b0;
      mispredict_count <= '0;
    end else begin
      update_valid <= w_res_acc;
      mispredict   <= w_mis;
      // Resolves during flush or on an empty queue are reported, never trained on.
      underflow    <= resolve_valid && !w_res_acc;
      if (w_res_acc) update_taken <= resolve_taken;
      if (w_mis && (mispredict_count != '1)) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
